// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcodes, instruction field positions and FSM states for alu_issue
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_XOR     = 3'b100,
    OP_ILLEGAL = 3'b101,
    OP_SLT     = 3'b110,
    OP_BZ      = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WB    = 2'b10
  } state_e;

  // Instruction layout: [15:13] op, [12:11] rd, [10:9] rs, [8:7] rt, [6:0] offset
  localparam int OP_LSB = 13;
  localparam int RD_LSB = 11;
  localparam int RS_LSB = 9;
  localparam int RT_LSB = 7;
  localparam int OFF_W  = 7;

  // Everything except BZ and the reserved opcode writes its result back
  function automatic logic op_writes(input op_e op);
    return !((op == OP_BZ) || (op == OP_ILLEGAL));
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction handshake, ALU and writeback/branch signals of alu_issue
interface alu_issue_if #(parameter int DW = 8);
  logic          in_valid;
  logic [15:0]   in_instr;
  logic          in_ready;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_ans;
  logic          alu_zero;
  logic          wb_valid;
  logic [1:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          br_taken;
  logic [6:0]    br_off;
  logic          illegal;

  // The issue block drives the ALU and the result side
  modport master (
    input  in_valid, in_instr, alu_ans, alu_zero,
    output in_ready, alu_op, alu_a, alu_b,
           wb_valid, wb_addr, wb_data, br_taken, br_off, illegal
  );

  // Fetch source and ALU seen from the other side
  modport slave (
    output in_valid, in_instr, alu_ans, alu_zero,
    input  in_ready, alu_op, alu_a, alu_b,
           wb_valid, wb_addr, wb_data, br_taken, br_off, illegal
  );
endinterface

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - 4 x DW register file, R0 hardwired to zero (ALU_ISSUE_DBG_EN adds a read port)
module alu_regfile #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ra_addr_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [1:0]    rb_addr_i,
  output logic [DW-1:0] rb_data_o,
`ifdef ALU_ISSUE_DBG_EN
  input  logic [1:0]    rc_addr_i,
  output logic [DW-1:0] rc_data_o,
`endif
  input  logic          we_i,
  input  logic [1:0]    waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] r1_q, r2_q, r3_q;

  function automatic logic [DW-1:0] sel_reg(input logic [1:0] addr, input logic [DW-1:0] x1,
                                            input logic [DW-1:0] x2, input logic [DW-1:0] x3);
    case (addr)
      2'd1:    return x1;
      2'd2:    return x2;
      2'd3:    return x3;
      default: return '0;
    endcase
  endfunction

  assign ra_data_o = sel_reg(ra_addr_i, r1_q, r2_q, r3_q);
  assign rb_data_o = sel_reg(rb_addr_i, r1_q, r2_q, r3_q);
`ifdef ALU_ISSUE_DBG_EN
  assign rc_data_o = sel_reg(rc_addr_i, r1_q, r2_q, r3_q);
`endif

  // Single write port; address 0 has no storage so writes to it vanish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else if (we_i) begin
      case (waddr_i)
        2'd1:    r1_q <= wdata_i;
        2'd2:    r2_q <= wdata_i;
        2'd3:    r3_q <= wdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - instruction issue to the 8-bit ALU with writeback/branch (optional ALU_ISSUE_DBG_EN debug read)
module alu_issue
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_if.master   bus
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`endif
);

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_e          state_q;
  logic [3:0]      cnt_q;
  op_e             alu_op_q;
  logic [DW-1:0]   alu_a_q, alu_b_q;
  logic [1:0]      rd_q;
  logic [OFF_W-1:0] off_q;
  logic            in_ready_q;
  logic            wb_valid_q;
  logic [1:0]      wb_addr_q;
  logic [DW-1:0]   wb_data_q;
  logic            br_taken_q;
  logic [OFF_W-1:0] br_off_q;
  logic            illegal_q;

  logic [DW-1:0]   rs_data, rt_data;
  op_e             in_op;

  assign in_op = op_e'(bus.in_instr[OP_LSB +: 3]);

  // The write lands at the end of the WB cycle, before the earliest next accept,
  // so a dependent instruction reads the new value without forwarding
  alu_regfile #(.DW(DW)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (bus.in_instr[RS_LSB +: 2]),
    .ra_data_o (rs_data),
    .rb_addr_i (bus.in_instr[RT_LSB +: 2]),
    .rb_data_o (rt_data),
`ifdef ALU_ISSUE_DBG_EN
    .rc_addr_i (dbg_addr),
    .rc_data_o (dbg_data),
`endif
    .we_i      (wb_valid_q),
    .waddr_i   (wb_addr_q),
    .wdata_i   (wb_data_q)
  );

  // Issue FSM: accept, hold ALU inputs for ALU_LAT cycles, then one result cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_op_q   <= OP_ADD;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      in_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      br_taken_q <= 1'b0;
      br_off_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            alu_op_q   <= in_op;
            alu_a_q    <= rs_data;
            alu_b_q    <= rt_data;
            rd_q       <= bus.in_instr[RD_LSB +: 2];
            off_q      <= bus.in_instr[OFF_W-1:0];
            cnt_q      <= LAT;
            in_ready_q <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_WB;
            if (op_writes(alu_op_q)) begin
              wb_valid_q <= 1'b1;
              wb_addr_q  <= rd_q;
              wb_data_q  <= bus.alu_ans;
            end else if (alu_op_q == OP_BZ) begin
              br_taken_q <= bus.alu_zero;
              br_off_q   <= off_q;
            end else begin
              illegal_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WB: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.br_taken = br_taken_q;
  assign bus.br_off   = br_off_q;
  assign bus.illegal  = illegal_q;

endmodule
